// File: rtl/instruction_fetch_pkg.sv
// Shared BIP definitions for the fetch stage: instruction field widths,
// default address/counter widths and the opcode map (HLT..SUBI). The same
// opcode values are used by instruction_decoder.
package instruction_fetch_pkg;

  localparam int BIP_OPCODE_LENGTH  = 5;
  localparam int BIP_OPERAND_LENGTH = 11;
  localparam int BIP_PC_LENGTH      = 11;
  localparam int BIP_CNT_LENGTH     = 32;

  // Instruction layout: opcode in instr[15:11], operand in instr[10:0].
  localparam int BIP_OPCODE_MSB  = 15;
  localparam int BIP_OPCODE_LSB  = 11;
  localparam int BIP_OPERAND_MSB = 10;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

endpackage

// File: rtl/instruction_fetch_pc.sv
// program_counter: PC_LENGTH-bit program counter register.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset (pc -> 0)
//   clear  in   synchronous clear to 0 (run start), has priority over incr
//   incr   in   advance pc by one; wraps from all-ones to 0 silently
//   pc     out  current program counter
module program_counter #(
  parameter int PC_LENGTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 incr,
  output logic [PC_LENGTH-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (incr) begin
      pc <= pc + PC_LENGTH'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: producer side of the opcode interface. Fetches 16-bit
// instructions from synchronous program memory and presents opcode/operand
// to instruction_decoder, advancing the PC on the decoder's WrPC. Stops on
// HLT and reports the number of clocks executed for the results stage.
// Ports:
//   clk, reset   clock (rising edge), asynchronous active-high reset
//   start        run request, honoured only in IDLE/HALTED
//   mem_rdata    program memory read data, valid one clock after mem_rd
//   wr_pc        WrPC from instruction_decoder, sampled only in EXEC
//   mem_addr     program memory address (the PC)
//   mem_rd       program memory read strobe (high in FETCH only)
//   opcode       instruction opcode field to the decoder
//   operand      instruction operand field to the datapath
//   instr_valid  opcode/operand belong to the instruction executing now
//   halted       HLT executed, core stopped
//   cycle_count  clocks from run start to HLT inclusive, saturating
//   dbgState     current FSM state (IDLE=0 FETCH=1 LATCH=2 EXEC=3 HALTED=4)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int OPCODE_LENGTH  = BIP_OPCODE_LENGTH,
  parameter int OPERAND_LENGTH = BIP_OPERAND_LENGTH,
  parameter int PC_LENGTH      = BIP_PC_LENGTH,
  parameter int CNT_LENGTH     = BIP_CNT_LENGTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [OPCODE_LENGTH+OPERAND_LENGTH-1:0] mem_rdata,
  input  logic                                    wr_pc,
  output logic [PC_LENGTH-1:0]                    mem_addr,
  output logic                                    mem_rd,
  output logic [OPCODE_LENGTH-1:0]                opcode,
  output logic [OPERAND_LENGTH-1:0]               operand,
  output logic                                    instr_valid,
  output logic                                    halted,
  output logic [CNT_LENGTH-1:0]                   cycle_count,
  output logic [2:0]                              dbgState
);

  localparam int INSTR_LENGTH = OPCODE_LENGTH + OPERAND_LENGTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  logic [2:0]              state;
  logic [2:0]              nextState;
  logic [INSTR_LENGTH-1:0] ir;
  logic [PC_LENGTH-1:0]    pc;
  logic                    pcClear;
  logic                    pcIncr;
  logic                    isHalt;
  logic                    running;

  // Opcode/operand are plain slices of the instruction register, so they
  // hold the last fetched word outside EXEC.
  // Interface contract: instr_valid is high for exactly the one EXEC clock of
  // each instruction; the decoder answers in that same clock with wr_pc=1 to
  // advance the PC or wr_pc=0 to have the same word fetched again. wr_pc is
  // ignored in every other state and on HLT.
  assign opcode   = ir[INSTR_LENGTH-1 -: OPCODE_LENGTH];
  assign operand  = ir[OPERAND_LENGTH-1:0];
  assign isHalt   = (opcode == OPCODE_LENGTH'(OP_HLT));
  assign running  = (state == ST_FETCH) || (state == ST_LATCH) || (state == ST_EXEC);
  assign mem_addr = pc;
  assign dbgState = state;

  always_comb begin
    nextState = state;
    pcClear   = 1'b0;
    pcIncr    = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          nextState = ST_FETCH;
          pcClear   = 1'b1;
        end
      end
      ST_FETCH: nextState = ST_LATCH;
      ST_LATCH: nextState = ST_EXEC;
      ST_EXEC: begin
        if (isHalt) begin
          nextState = ST_HALTED;
        end else begin
          nextState = ST_FETCH;
          pcIncr    = wr_pc;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  program_counter #(
    .PC_LENGTH(PC_LENGTH)
  ) u_pc (
    .clk  (clk),
    .reset(reset),
    .clear(pcClear),
    .incr (pcIncr),
    .pc   (pc)
  );

  // State-qualified outputs are registered from nextState so they line up
  // with the state they describe without any combinational output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= nextState;
      mem_rd      <= (nextState == ST_FETCH);
      instr_valid <= (nextState == ST_EXEC);
      halted      <= (nextState == ST_HALTED);
      if (state == ST_LATCH) begin
        ir <= mem_rdata;
      end
    end
  end

  // Counts every FETCH/LATCH/EXEC clock (including the HLT EXEC), frozen
  // while idle or halted, and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (pcClear) begin
      cycle_count <= '0;
    end else if (running && (cycle_count != {CNT_LENGTH{1'b1}})) begin
      cycle_count <= cycle_count + CNT_LENGTH'(1);
    end
  end

endmodule
